// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch / count-down timer engine with lap freeze and
// an internal tick prescaler. All outputs are registered; single board clock.
module stopwatch_core #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned HOUR_DIGITS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_stop,
    input  logic                           clear,
    input  logic                           lap,
    input  logic                           down,
    input  logic                           load,
    input  logic [4*(4+HOUR_DIGITS)-1:0]   load_value,
    output logic [4*(4+HOUR_DIGITS)-1:0]   digits,
    output logic                           running,
    output logic                           lap_active,
    output logic                           tick,
    output logic                           done
);

    localparam int unsigned NDIG = 4 + HOUR_DIGITS;
    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StStopped, StRunning, StExpired} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  live_q, live_d;
    logic [W-1:0]  snap_q, snap_d;
    logic [W-1:0]  digits_q;
    logic [W-1:0]  next_cnt;
    logic          lap_q, lap_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          running_q;
    logic          ss_taken;

    // Tens-of-seconds and tens-of-minutes digits stop at 5; everything else at 9.
    function automatic logic [3:0] dig_max(input int i);
        return (i == 1 || i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                if (v[4*i +: 4] == dig_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = dig_max(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > dig_max(i)) ? dig_max(i) : v[4*i +: 4];
        end
        return r;
    endfunction

    // Next-state: events resolved in priority order clear > load > start_stop > lap > tick.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        live_d   = live_q;
        snap_d   = snap_q;
        lap_d    = lap_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        ss_taken = 1'b0;
        next_cnt = down ? bcd_dec(live_q) : bcd_inc(live_q);

        if (clear) begin
            live_d  = '0;
            lap_d   = 1'b0;
            presc_d = '0;
            state_d = StStopped;
        end else if (load && state_q != StRunning) begin
            live_d  = bcd_sat(load_value);
            lap_d   = 1'b0;
            presc_d = '0;
            state_d = StStopped;
        end else begin
            if (start_stop && state_q == StStopped && !(down && live_q == '0)) begin
                state_d  = StRunning;
                ss_taken = 1'b1;
            end else if (start_stop && state_q == StRunning) begin
                state_d  = StStopped;
                ss_taken = 1'b1;
            end

            if (!ss_taken && lap) begin
                if (lap_q) begin
                    lap_d = 1'b0;
                end else if (state_q == StRunning) begin
                    lap_d  = 1'b1;
                    snap_d = live_q;
                end
            end

            if (state_q == StRunning) begin
                presc_d = (presc_q == PrescMax) ? '0 : presc_q + PW'(1);
                // A tick that lands on a stop pulse is dropped.
                if (presc_q == PrescMax && !ss_taken) begin
                    tick_d = 1'b1;
                    live_d = next_cnt;
                    if (down && next_cnt == '0) begin
                        state_d = StExpired;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    // State and registered outputs; display mux is resolved before the flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StStopped;
            presc_q   <= '0;
            live_q    <= '0;
            snap_q    <= '0;
            lap_q     <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            digits_q  <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            live_q    <= live_d;
            snap_q    <= snap_d;
            lap_q     <= lap_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            digits_q  <= lap_d ? snap_d : live_d;
            running_q <= (state_d == StRunning);
        end
    end

    assign digits     = digits_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign tick       = tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core (TICK_DIV=4, HOUR_DIGITS=1) with a queue of
// expected display values consumed on each tick.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic        down = 1'b0;
    logic        load = 1'b0;
    logic [19:0] load_value = '0;
    logic [19:0] digits;
    logic        running;
    logic        lap_active;
    logic        tick;
    logic        done;

    int          vectors = 0;
    int          miscompares = 0;
    logic [19:0] expq[$];

    stopwatch_core #(
        .TICK_DIV   (4),
        .HOUR_DIGITS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .down      (down),
        .load      (load),
        .load_value(load_value),
        .digits    (digits),
        .running   (running),
        .lap_active(lap_active),
        .tick      (tick),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step();
        lap = 1'b0;
    endtask

    task automatic do_load(input logic [19:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Wait (bounded) for the next tick, then check latency and popped display value.
    task automatic expect_tick(input string tag, input int lat);
        int          n;
        logic [19:0] e;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 20);
        e = (expq.size() > 0) ? expq.pop_front() : 20'hFFFFF;
        check({tag, "_lat"}, n, lat);
        check({tag, "_dig"}, {12'd0, digits}, {12'd0, e});
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_digits", {12'd0, digits}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_lap", {31'd0, lap_active}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Up-count cadence
        pulse_ss();
        check("up_running", {31'd0, running}, 32'd1);
        expq.push_back(20'h00001);
        expect_tick("up1", 4);
        expq.push_back(20'h00002);
        expect_tick("up2", 4);
        pulse_ss();
        check("up_stop", {31'd0, running}, 32'd0);

        // Wrap from maximum
        do_load(20'h95958);
        check("wrap_load", {12'd0, digits}, 32'h95958);
        pulse_ss();
        expq.push_back(20'h95959);
        expect_tick("wrap1", 4);
        expq.push_back(20'h00000);
        expect_tick("wrap2", 4);
        check("wrap_done", {31'd0, done}, 32'd0);
        check("wrap_running", {31'd0, running}, 32'd1);
        pulse_ss();

        // Carry chain
        do_load(20'h00959);
        pulse_ss();
        expq.push_back(20'h01000);
        expect_tick("carry_min", 4);
        pulse_ss();
        do_load(20'h05959);
        pulse_ss();
        expq.push_back(20'h10000);
        expect_tick("carry_hr", 4);
        pulse_ss();

        // Count-down expiry
        do_load(20'h00002);
        down = 1'b1;
        pulse_ss();
        expq.push_back(20'h00001);
        expect_tick("dn1", 4);
        expq.push_back(20'h00000);
        expect_tick("dn0", 4);
        check("dn_done", {31'd0, done}, 32'd1);
        check("dn_running", {31'd0, running}, 32'd0);
        step();
        check("dn_done_once", {31'd0, done}, 32'd0);
        pulse_ss();
        check("exp_ss_ignored", {31'd0, running}, 32'd0);
        pulse_clear();
        check("exp_clear_dig", {12'd0, digits}, 32'd0);
        pulse_ss();
        check("zero_down_ss_ignored", {31'd0, running}, 32'd0);
        down = 1'b0;
        pulse_ss();
        check("clear_to_stopped", {31'd0, running}, 32'd1);
        pulse_ss();

        // Lap freeze
        pulse_clear();
        pulse_ss();
        expq.push_back(20'h00001);
        expect_tick("lap_t1", 4);
        expq.push_back(20'h00002);
        expect_tick("lap_t2", 4);
        expq.push_back(20'h00003);
        expect_tick("lap_t3", 4);
        pulse_lap();
        check("lap_on", {31'd0, lap_active}, 32'd1);
        check("lap_snap", {12'd0, digits}, 32'h00003);
        expq.push_back(20'h00003);
        expect_tick("lap_f4", 3);
        expq.push_back(20'h00003);
        expect_tick("lap_f5", 4);
        expq.push_back(20'h00003);
        expect_tick("lap_f6", 4);
        pulse_lap();
        check("lap_off", {31'd0, lap_active}, 32'd0);
        check("lap_live", {12'd0, digits}, 32'h00006);
        pulse_ss();

        // Priority and saturation
        clear = 1'b1;
        start_stop = 1'b1;
        step();
        clear = 1'b0;
        start_stop = 1'b0;
        check("prio_running", {31'd0, running}, 32'd0);
        check("prio_digits", {12'd0, digits}, 32'd0);
        do_load(20'h0007C);
        check("sat_load", {12'd0, digits}, 32'h00059);
        pulse_ss();
        check("run_again", {31'd0, running}, 32'd1);
        do_load(20'h12345);
        check("load_run_ignored", {12'd0, digits}, 32'h00059);
        check("load_run_state", {31'd0, running}, 32'd1);

        // Asynchronous reset mid-prescale with lap frozen
        pulse_lap();
        check("pre_rst_lap", {31'd0, lap_active}, 32'd1);
        step();
        #3;
        rst = 1'b1;
        #1;
        check("arst_digits", {12'd0, digits}, 32'd0);
        check("arst_running", {31'd0, running}, 32'd0);
        check("arst_lap", {31'd0, lap_active}, 32'd0);
        check("arst_tick", {31'd0, tick}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_running", {31'd0, running}, 32'd0);
        check("post_rst_tick", {31'd0, tick}, 32'd0);
        pulse_ss();
        expq.push_back(20'h00001);
        expect_tick("post_rst_t1", 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised BCD stopwatch/timer engine sitting between the button FSMs (`fsm_boton` pulses) and the seven-segment conversion and drawing path of the VGA stopwatch. It replaces the fixed H:MM:SS up-counter with a configurable-width core that adds:

- a count-down mode with a loadable preset and expiry flag;
- a lap/split freeze of the displayed value;
- an internal tick prescaler, so no derived clock is needed.

All logic runs on the single board clock.

## Interface
Parameters:
- `TICK_DIV`, 50000000: board-clock cycles per count unit (1 s at 50 MHz); legal range ≥ 2.
- `HOUR_DIGITS`, 1: number of BCD hour digits; legal values are 1 or 2.

Derived: `NDIG = 4 + HOUR_DIGITS`.

Ports:
- Reset policy: one clock; reset is asynchronous and active-high.
- `clk`  in  1  board clock.
- `rst`  in  1  asynchronous active-high reset.
- `start_stop`  in  1  one-cycle pulse; toggles run/stop.
- `clear`  in  1  one-cycle pulse; zero the count.
- `lap`  in  1  one-cycle pulse; toggle lap freeze.
- `down`  in  1  level; 1 = count down, 0 = count up.
- `load`  in  1  one-cycle pulse; load the preset.
- `load_value`  in  4*NDIG  BCD preset, packed as {hours…, min tens, min units, sec tens, sec units}, sec units in [3:0].
- `digits`  out  4*NDIG  displayed BCD value, same packing.
- `running`  out  1  high in RUNNING.
- `lap_active`  out  1  high while the display is frozen.
- `tick`  out  1  one-cycle pulse when the live count changes.
- `done`  out  1  one-cycle pulse on count-down expiry.

## Operation
States: STOPPED, RUNNING, EXPIRED. Reset enters STOPPED.

Transitions:
- STOPPED → RUNNING on `start_stop`. Exception: if `down`=1 and the count is all-zero, the pulse is ignored.
- RUNNING → STOPPED on `start_stop`.
- RUNNING → EXPIRED when a down-tick makes the count all-zero.
- EXPIRED → STOPPED on `clear` or `load`. `start_stop` is ignored in EXPIRED.

Prescaler:
- Counter runs 0..TICK_DIV-1 only in RUNNING.
- It holds in STOPPED and EXPIRED, so a resume keeps the partial period.
- `clear`, `load` and reset zero it.
- Counter width is $clog2(TICK_DIV).

Count update: on the edge where the prescaler equals TICK_DIV-1 in RUNNING.
- Digit ranges: sec units 0–9, sec tens 0–5, min units 0–9, min tens 0–5, hours 0..10^HOUR_DIGITS-1.
- Up mode: carry ripples across digits in one cycle. From maximum (9:59:59 with HOUR_DIGITS=1) the count wraps to all-zero, with no `done`; it keeps running.
- Down mode: borrow ripples in one cycle. Reaching zero enters EXPIRED on that same edge and pulses `done`.
- `down` is sampled at each tick edge, so a mid-run change takes effect on the next tick.

Lap:
- `lap` in RUNNING with `lap_active`=0 snapshots the live count and sets `lap_active`.
- `lap` with `lap_active`=1 clears it in any state.
- `lap` with `lap_active`=0 outside RUNNING is ignored.
- While `lap_active`=1, `digits` shows the snapshot; otherwise it shows the live count. The live count keeps advancing while frozen.

`clear`: live count := 0, `lap_active` := 0, and the state machine goes to STOPPED (applies from any state).

`load`:
- Honoured in STOPPED or EXPIRED only; ignored in RUNNING.
- Each field is saturated to its range (e.g. a sec-tens value of 7 becomes 5; a units value of 0xC becomes 9).
- Clears `lap_active`; the state machine goes to STOPPED.

Priority for events on the same cycle, highest first:
1. `clear`
2. `load`
3. `start_stop`
4. `lap`
5. the prescaler tick

A tick coinciding with `start_stop` in RUNNING is dropped: the count is not updated.

## Timing
- All outputs are registered.
- Reset values: `digits`=0, `running`=0, `lap_active`=0, `tick`=0, `done`=0, prescaler=0.
- Latency from a control pulse to its effect is one edge. `running` and `lap_active` are valid in the cycle after the pulse.
- `tick` and `done` are high in exactly the cycle in which the new count first appears on `digits` (when not frozen).
- The first tick after entering RUNNING from a fresh clear arrives TICK_DIV cycles after the `start_stop` edge.
- Assertion of `rst` immediately forces reset values, even mid-tick or mid-lap. No pulse is generated on release.

## Test plan
Bench settings: TICK_DIV=4, HOUR_DIGITS=1.
- **Up-count and wrap:** reset, pulse `start_stop`.
  - `tick` every 4 cycles, starting 4 cycles after the pulse.
  - After `load` 9:59:58 (while stopped) then 2 ticks, `digits` reads 0:00:00; `running` stays 1 and `done` stays 0.
- **Carry chain:** load 0:09:59, run 1 tick → 0:10:00. Load 0:59:59, run 1 tick → 1:00:00.
- **Count-down expiry:**
  - load 0:00:02, `down`=1, start → 0:00:01, then 0:00:00 with a one-cycle `done`; `running`=0.
  - A further `start_stop` is ignored.
  - `clear` then returns to STOPPED.
- **Lap:** run to 0:00:03, pulse `lap` → `digits` holds 0:00:03 for 3 ticks while the live count reaches 0:00:06. Pulse `lap` again → `digits` shows 0:00:06.
- **Priority and saturation:**
  - `clear` and `start_stop` in the same cycle from STOPPED → stays STOPPED, count 0.
  - `load` with `load_value` sec-tens=7, units=0xC → 0:00:59.
  - `load` while RUNNING is ignored.
- **Async reset:** assert `rst` mid-prescale with the lap frozen → all outputs are 0 before the next clock edge. After release, STOPPED; a `start_stop` pulse gives its first tick 4 cycles later.
